// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: shifts an operand by up to STEP bits per clock
// (SLL/SRL/SRA/ROTR), with valid/ready handshakes on request and result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// SHIFT | working register shifted by min(STEP, remaining) each cycle
// DONE  | result held on data_out with out_valid high until out_ready
module seq_shifter #(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  // One extra bit so STEP == WIDTH is representable as a step amount.
  localparam int                 AMT_W  = SHAMT_W + 1;
  localparam logic [AMT_W-1:0]   STEP_C = AMT_W'(STEP);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [1:0]           op_q, op_d;

  logic [AMT_W-1:0]     rem_ext;
  logic [AMT_W-1:0]     amt;
  logic [AMT_W-1:0]     rem_left;
  logic [2*WIDTH-1:0]   rot_dbl;
  logic [WIDTH-1:0]     shifted;

  // Step amount for this cycle and the working register shifted by it.
  // SRA stays correct across steps because the arithmetic shift keeps
  // replicating the MSB, which never changes from the original sign.
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    amt      = (rem_ext < STEP_C) ? rem_ext : STEP_C;
    rem_left = rem_ext - amt;
    rot_dbl  = {work_q, work_q} >> amt;
    shifted  = work_q;
    case (op_q)
      OP_SLL:  shifted = work_q << amt;
      OP_SRL:  shifted = work_q >> amt;
      OP_SRA:  shifted = $signed(work_q) >>> amt;
      OP_ROTR: shifted = rot_dbl[WIDTH-1:0];
      default: shifted = work_q;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          op_d    = op;
          rem_d   = shamt;
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_left[SHAMT_W-1:0];
        if (rem_left == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: a STEP=1 and a STEP=4 instance share one stimulus
// port, selected by sel; results are checked against a bit-serial model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic        out_ready = 1'b0;

  logic        ir1, ov1, bz1, ir4, ov4, bz4;
  logic [31:0] do1, do4;
  logic        in_ready_m, out_valid_m, busy_m;
  logic [31:0] data_out_m;

  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;
  logic acc_flag = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir1),
    .op(op), .data_in(data_in), .shamt(shamt), .out_valid(ov1),
    .out_ready(out_ready & ~sel), .data_out(do1), .busy(bz1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir4),
    .op(op), .data_in(data_in), .shamt(shamt), .out_valid(ov4),
    .out_ready(out_ready & sel), .data_out(do4), .busy(bz4)
  );

  assign in_ready_m  = sel ? ir4 : ir1;
  assign out_valid_m = sel ? ov4 : ov1;
  assign busy_m      = sel ? bz4 : bz1;
  assign data_out_m  = sel ? do4 : do1;

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) begin
      case (o)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {d[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push model result on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_flag = 1'b0;
    end else begin
      acc_flag = in_valid && in_ready_m;
      if (acc_flag) exp_q.push_back(ref_shift(op, data_in, shamt));
      if (out_valid_m && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: unexpected result %h with no request pending", data_out_m);
        end else begin
          chk("scoreboard", data_out_m, exp_q.pop_front());
        end
      end
    end
  end

  // Issue one request, measure edges from accept to out_valid, then drain it.
  task automatic run_op(input logic s, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] sa, input logic [31:0] exp, input int exp_lat,
                        input string name);
    int lat;
    bit ok;
    sel = s; op = o; data_in = d; shamt = sa; in_valid = 1'b1; out_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready_m) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk({name, " accept"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid_m) begin ok = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " data"}, data_out_m, exp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] held;
    int edges;
    int cyc;
    int sent;
    int pop_base;
    bit acc_now;

    vecs[0] = '{1'b0, 2'b00, 32'h80000001, 5'd4,  32'h00000010, 4};
    vecs[1] = '{1'b0, 2'b01, 32'h80000001, 5'd4,  32'h08000000, 4};
    vecs[2] = '{1'b0, 2'b10, 32'h80000001, 5'd4,  32'hF8000000, 4};
    vecs[3] = '{1'b0, 2'b11, 32'h80000001, 5'd4,  32'h18000000, 4};
    vecs[4] = '{1'b0, 2'b10, 32'h12345678, 5'd0,  32'h12345678, 0};
    vecs[5] = '{1'b0, 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 31};
    vecs[6] = '{1'b1, 2'b01, 32'hF0000000, 5'd7,  32'h01E00000, 2};
    vecs[7] = '{1'b1, 2'b00, 32'hFFFFFFFF, 5'd31, 32'h80000000, 8};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(ir1), 32'd1);
    chk("reset out_valid", 32'(ov1 | ov4), 32'd0);
    chk("reset busy", 32'(bz1 | bz4), 32'd0);
    chk("reset data_out", do1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a long STEP=1 shift.
    sel = 1'b0; op = 2'b00; data_in = 32'hDEADBEEF; shamt = 5'd20; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready_m) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset busy", 32'(busy_m), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid reset in_ready", 32'(in_ready_m), 32'd1);
    chk("mid reset out_valid", 32'(out_valid_m), 32'd0);
    chk("mid reset busy", 32'(busy_m), 32'd0);
    chk("mid reset data_out", data_out_m, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("post reset no result", 32'(out_valid_m), 32'd0);
    end
    @(posedge clk); #1;
    run_op(1'b0, 2'b00, 32'h00000001, 5'd1, 32'h00000002, 1, "post reset sll");

    for (int v = 0; v < 8; v++)
      run_op(vecs[v].sel, vecs[v].op, vecs[v].data, vecs[v].shamt, vecs[v].exp,
             vecs[v].lat, $sformatf("vec%0d", v));

    // Back-pressure: hold the result for 10 cycles with stray request pulses.
    sel = 1'b0; op = 2'b00; data_in = 32'h00000003; shamt = 5'd2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready_m) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_m) break;
      @(posedge clk); #1;
    end
    held = data_out_m;
    chk("bp result", held, 32'h0000000C);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      data_in = 32'h5555AAAA;
      shamt = 5'd3;
      @(negedge clk);
      chk("bp data stable", data_out_m, held);
      chk("bp in_ready low", 32'(in_ready_m), 32'd0);
      chk("bp out_valid held", 32'(out_valid_m), 32'd1);
    end
    @(posedge clk); #1;
    op = 2'b01; data_in = 32'h00000100; shamt = 5'd1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    edges = 0;
    acc_now = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready_m;
      @(posedge clk);
      edges++;
      #1;
      out_ready = 1'b0;
      if (acc_now) break;
    end
    chk("bp next accept edges", 32'(edges), 32'd2);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_m) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Streaming with random handshakes, 100 requests per instance.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      sent = 0;
      cyc = 0;
      pop_base = n_pop;
      while ((sent < 100 || in_valid || exp_q.size() > 0) && cyc < 20000) begin
        @(posedge clk); #1;
        cyc++;
        if (acc_flag) in_valid = 1'b0;
        if (!in_valid && sent < 100 && $urandom_range(0, 1) == 1) begin
          in_valid = 1'b1;
          op = 2'($urandom_range(0, 3));
          data_in = $urandom();
          shamt = 5'($urandom_range(0, 31));
          sent++;
        end
        out_ready = (sent >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      out_ready = 1'b0;
      chk("stream drained", 32'(exp_q.size()), 32'd0);
      chk("stream result count", 32'(n_pop - pop_base), 32'd100);
      repeat (2) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
